// File: rtl/fetch_pkg.sv
// Shared fetch-stage types: prediction kinds and the sequential fetch-block helper.
package fetch_pkg;

  typedef enum logic [1:0] {
    PRED_JUMP = 2'd0,
    PRED_CALL = 2'd1,
    PRED_RET  = 2'd2,
    PRED_RSVD = 2'd3
  } pred_type_e;

  localparam int FETCH_MAX_XLEN = 64;

  // Start of the next fetch block; callers truncate to their own XLEN, which
  // gives the modulo-2^XLEN wrap for free.
  function automatic logic [FETCH_MAX_XLEN-1:0] fetch_seq_pc(
    input logic [FETCH_MAX_XLEN-1:0] pc,
    input int unsigned               fetch_bytes
  );
    logic [FETCH_MAX_XLEN-1:0] blk;
    blk = FETCH_MAX_XLEN'(fetch_bytes);
    return (pc & ~(blk - 1'b1)) + blk;
  endfunction

endpackage

// File: rtl/fetch_ras.sv
// Circular return-address stack; a push when full overwrites the oldest entry.
module fetch_ras
  import fetch_pkg::*;
#(
  parameter int RAS_DEPTH = 8,
  parameter int XLEN      = 32
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push,
  input  logic                       pop,
  input  logic [XLEN-1:0]            push_addr,
  output logic [XLEN-1:0]            top,
  output logic [$clog2(RAS_DEPTH):0] count
);
  localparam int            PW   = $clog2(RAS_DEPTH);
  localparam logic [PW:0]   FULL = (PW+1)'(RAS_DEPTH);

  logic [XLEN-1:0] mem_q [RAS_DEPTH];
  logic [PW-1:0]   ptr_q;
  logic [PW:0]     cnt_q;

  // ptr_q names the next free slot, so the top lives one below it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < RAS_DEPTH; i++) mem_q[i] <= '0;
      ptr_q <= '0;
      cnt_q <= '0;
    end else if (push) begin
      mem_q[ptr_q] <= push_addr;
      ptr_q        <= ptr_q + 1'b1;
      if (cnt_q != FULL) cnt_q <= cnt_q + 1'b1;
    end else if (pop && cnt_q != '0) begin
      ptr_q <= ptr_q - 1'b1;
      cnt_q <= cnt_q - 1'b1;
    end
  end

  assign top   = mem_q[ptr_q - 1'b1];
  assign count = cnt_q;

endmodule

// File: rtl/fetch_pc_gen.sv
// Next-fetch-PC selection: redirect > prediction > sequential > hold.
// Define FETCH_RAS_EN to build the return-address stack; otherwise CALL/RET act as JUMP.
module fetch_pc_gen
  import fetch_pkg::*;
#(
  parameter int              XLEN        = 32,
  parameter int              FETCH_BYTES = 4,
  parameter int              RAS_DEPTH   = 8,
  parameter logic [XLEN-1:0] RESET_PC    = '0
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       redirect_valid,
  input  logic [XLEN-1:0]            redirect_pc,
  input  logic                       pred_valid,
  input  logic [1:0]                 pred_type,
  input  logic [XLEN-1:0]            pred_target,
  input  logic [XLEN-1:0]            pred_link,
  input  logic                       fetch_ready,
  output logic                       fetch_valid,
  output logic [XLEN-1:0]            fetch_pc,
  output logic [$clog2(RAS_DEPTH):0] ras_count
);
  localparam int CW = $clog2(RAS_DEPTH) + 1;

  logic            fetch_valid_q;
  logic [XLEN-1:0] fetch_pc_q, pc_d, seq_pc;
  logic [XLEN-1:0] ras_top;
  logic [CW-1:0]   ras_cnt;
  logic            ras_push, ras_pop, pred_hit, hs;
  pred_type_e      pt;

  assign pt       = pred_type_e'(pred_type);
  assign pred_hit = pred_valid && (pt != PRED_RSVD);
  assign hs       = fetch_valid_q && fetch_ready;
  assign seq_pc   = XLEN'(fetch_seq_pc(FETCH_MAX_XLEN'(fetch_pc_q), FETCH_BYTES));

  always_comb begin
    pc_d     = fetch_pc_q;
    ras_push = 1'b0;
    ras_pop  = 1'b0;
    if (redirect_valid) begin
      pc_d = redirect_pc;
    end else if (pred_hit) begin
      case (pt)
        PRED_CALL: begin
          pc_d     = pred_target;
          ras_push = 1'b1;
        end
        PRED_RET: begin
          // Empty stack falls back to the predecoded target without popping.
          if (ras_cnt != '0) begin
            pc_d    = ras_top;
            ras_pop = 1'b1;
          end else begin
            pc_d = pred_target;
          end
        end
        default: pc_d = pred_target;
      endcase
    end else if (hs) begin
      pc_d = seq_pc;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fetch_valid_q <= 1'b0;
      fetch_pc_q    <= RESET_PC;
    end else begin
      fetch_valid_q <= 1'b1;
      fetch_pc_q    <= pc_d;
    end
  end

`ifdef FETCH_RAS_EN
  fetch_ras #(
    .RAS_DEPTH (RAS_DEPTH),
    .XLEN      (XLEN)
  ) u_ras (
    .clk       (clk),
    .rst       (rst),
    .push      (ras_push),
    .pop       (ras_pop),
    .push_addr (pred_link),
    .top       (ras_top),
    .count     (ras_cnt)
  );
`else
  // With no stack, a zero count steers RET to pred_target and CALL never pushes.
  assign ras_top = '0;
  assign ras_cnt = '0;
  logic unused_ras;
  assign unused_ras = ras_push ^ ras_pop ^ (^pred_link) ^ (^ras_top);
`endif

  assign fetch_valid = fetch_valid_q;
  assign fetch_pc    = fetch_pc_q;
  assign ras_count   = ras_cnt;

endmodule

// File: tb/tb_fetch_pc_gen.sv
// Directed + random bench for fetch_pc_gen against a queue-based reference model.
module tb_fetch_pc_gen;
  localparam int          XLEN  = 32;
  localparam int          FB    = 4;
  localparam int          DEPTH = 8;
  localparam logic [31:0] RPC   = 32'h1000;
`ifdef FETCH_RAS_EN
  localparam bit RAS_EN = 1'b1;
`else
  localparam bit RAS_EN = 1'b0;
`endif

  logic        clk = 1'b0, rst = 1'b1;
  logic        redirect_valid = 1'b0, pred_valid = 1'b0, fetch_ready = 1'b0;
  logic [31:0] redirect_pc = '0, pred_target = '0, pred_link = '0;
  logic [1:0]  pred_type = '0;
  logic        fetch_valid;
  logic [31:0] fetch_pc;
  logic [3:0]  ras_count;

  int n_assert = 0, n_fail = 0;

  // Reference state: plain valid/pc plus a bounded queue for the stack.
  logic        m_valid;
  logic [31:0] m_pc;
  logic [31:0] m_ras[$];

  fetch_pc_gen #(.XLEN(XLEN), .FETCH_BYTES(FB), .RAS_DEPTH(DEPTH), .RESET_PC(RPC)) dut (
    .clk(clk), .rst(rst), .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .pred_valid(pred_valid), .pred_type(pred_type), .pred_target(pred_target),
    .pred_link(pred_link), .fetch_ready(fetch_ready), .fetch_valid(fetch_valid),
    .fetch_pc(fetch_pc), .ras_count(ras_count));

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_all(input string tag);
    chk({tag, ".valid"}, 64'(fetch_valid), 64'(m_valid));
    chk({tag, ".pc"},    64'(fetch_pc),    64'(m_pc));
    chk({tag, ".cnt"},   64'(ras_count),   64'(m_ras.size()));
  endtask

  task automatic model_reset();
    m_valid = 1'b0;
    m_pc    = RPC;
    m_ras.delete();
  endtask

  // Next state from the priority rules, evaluated on the inputs before the edge.
  task automatic tick(input string tag);
    logic [31:0] npc;
    npc = m_pc;
    if (redirect_valid) npc = redirect_pc;
    else if (pred_valid && pred_type != 2'd3) begin
      npc = pred_target;
      if (RAS_EN && pred_type == 2'd1) begin
        if (m_ras.size() == DEPTH) void'(m_ras.pop_front());
        m_ras.push_back(pred_link);
      end else if (RAS_EN && pred_type == 2'd2 && m_ras.size() > 0) begin
        npc = m_ras.pop_back();
      end
    end else if (m_valid && fetch_ready) npc = (m_pc / FB) * FB + FB;
    @(posedge clk);
    #1;
    m_pc    = npc;
    m_valid = 1'b1;
    chk_all(tag);
  endtask

  task automatic set_in(input logic rv, input logic [31:0] rpc, input logic pv,
                        input logic [1:0] pt, input logic [31:0] tgt,
                        input logic [31:0] lnk, input logic rdy);
    redirect_valid = rv; redirect_pc = rpc; pred_valid = pv; pred_type = pt;
    pred_target = tgt; pred_link = lnk; fetch_ready = rdy;
  endtask

  initial begin
    model_reset();
    set_in(0, 0, 0, 0, 0, 0, 1);
    repeat (2) @(posedge clk);
    #3;
    chk_all("reset");
    rst = 1'b0;

    // Reset release: 0x1000, 0x1004, 0x1008 back to back.
    repeat (3) tick("seq");

    // Stall on an unaligned PC, then resume to the next block.
    set_in(1, 32'h1006, 0, 0, 0, 0, 0); tick("redir_1006");
    set_in(0, 0, 0, 0, 0, 0, 0);
    repeat (3) tick("stall");
    fetch_ready = 1'b1; tick("unaligned_seq");

    // CALL/RET pair.
    set_in(0, 0, 1, 2'd1, 32'h2000, 32'h1010, 1); tick("call");
    set_in(0, 0, 1, 2'd2, 32'h7777, 0, 1);        tick("ret");

    // Redirect wins over a coincident CALL; RET on empty stack uses target.
    set_in(1, 32'h3000, 1, 2'd1, 32'h2222, 32'h5555, 1); tick("redir_vs_call");
    set_in(0, 0, 1, 2'd2, 32'h4000, 0, 1);               tick("ret_empty");
    set_in(0, 0, 1, 2'd3, 32'h9999, 0, 1);               tick("rsvd_type");

    // Overfill: 9 calls, then 8 returns.
    for (int k = 1; k <= 9; k++) begin
      set_in(0, 0, 1, 2'd1, 32'h8000 + 32'(k) * 16, 32'(k) * 32'h100, 0);
      tick("call_fill");
    end
    for (int k = 0; k < 8; k++) begin
      set_in(0, 0, 1, 2'd2, 32'hA000, 0, 0);
      tick("ret_drain");
    end

    // Wrap at the top of the address space.
    set_in(1, 32'hFFFF_FFFC, 0, 0, 0, 0, 0); tick("redir_top");
    set_in(0, 0, 0, 0, 0, 0, 1);             tick("wrap");

    // Random traffic.
    for (int i = 0; i < 300; i++) begin
      set_in($urandom_range(0, 9) == 0, $urandom, $urandom_range(0, 9) < 4,
             2'($urandom_range(0, 3)), $urandom, $urandom, 1'($urandom_range(0, 1)));
      tick("rand");
    end

    // Load the stack, then reset asynchronously between edges.
    set_in(0, 0, 1, 2'd1, 32'hB000, 32'hC000, 1); tick("pre_rst_call");
    set_in(0, 0, 0, 0, 0, 0, 1);
    @(posedge clk);
    #3;
    rst = 1'b1;
    #1;
    model_reset();
    chk_all("async_rst");
    #3;
    chk_all("async_rst_hold");
    rst = 1'b0;
    tick("post_rst");
    set_in(0, 0, 1, 2'd2, 32'h5550, 0, 1); tick("post_rst_ret");

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
